// File: rtl/vga_frame_buffer_pkg.sv
// Shared constants, types and helpers for the double-buffered VGA cell frame buffer.
// Holds the 640x480@60 timing figures used by the downstream timing stage, the cell-grid
// geometry, the control FSM state encoding and the cell-address helper.
package vga_frame_buffer_pkg;

  // Horizontal timing, in pixel clocks
  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = 800;

  // Vertical timing, in lines
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = 525;

  // Cell grid geometry
  localparam int unsigned GRID_W     = 160;
  localparam int unsigned GRID_H     = 120;
  localparam int unsigned CELL_SHIFT = 2;
  localparam int unsigned ADDR_W     = 15;
  localparam int unsigned RGB_W      = 3;
  localparam int unsigned CELLS      = GRID_W * GRID_H;

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
  localparam logic [7:0]        LAST_X    = 8'(GRID_W - 1);
  localparam logic [6:0]        LAST_Y    = 7'(GRID_H - 1);

  typedef enum logic {
    StIdle  = 1'b0,
    StClear = 1'b1
  } fb_state_e;

  // Row-major cell index; y*160 built from two shifts so no multiplier is inferred.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] y, input logic [7:0] x);
    logic [ADDR_W-1:0] yw;
    yw = ADDR_W'(y);
    return (yw << 7) + (yw << 5) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/vga_frame_buffer_if.sv
// Game-logic side of the frame buffer: cell write handshake plus clear and swap control.
//  wr_valid/wr_ready  write handshake, transfer on wr_valid & wr_ready
//  wr_x, wr_y, wr_rgb cell column (8b), cell row (7b), {r,g,b} colour
//  clear_req/busy     clear pulse and in-progress flag
//  swap_req/done      swap request pulse and one-cycle exchange strobe
// master = game logic, slave = frame buffer.
interface vga_frame_buffer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_x;
  logic [6:0] wr_y;
  logic [2:0] wr_rgb;
  logic       clear_req;
  logic       clear_busy;
  logic       swap_req;
  logic       swap_done;

  modport master (
    output wr_valid, wr_x, wr_y, wr_rgb, clear_req, swap_req,
    input  wr_ready, clear_busy, swap_done
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_rgb, clear_req, swap_req,
    output wr_ready, clear_busy, swap_done
  );
endinterface

// File: rtl/vga_frame_buffer_ram.sv
// Simple dual-port pixel RAM: one synchronous write port, one registered read port.
//  clk           clock for both ports
//  we/waddr/wdata write enable, address, data
//  raddr/rdata   read address, registered read data (one-cycle latency)
// No reset: contents are undefined until written.
module vga_frame_buffer_ram #(
  parameter int unsigned AddrW = 16,
  parameter int unsigned DataW = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [DataW-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [DataW-1:0] rdata
);

  logic [DataW-1:0] mem [2**AddrW];
  logic [DataW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vga_frame_buffer.sv
// Double-buffered 160x120 cell store feeding the VGA timing stage, each cell drawn as 4x4 pixels.
// Game logic writes/clears the back bank; the front bank streams out with a fixed 2-cycle
// latency. Bank exchange happens only on frame_start, so a frame never tears.
//  clk, reset      pixel clock, asynchronous active-high reset
//  bus             game-logic write/clear/swap interface (slave side)
//  frame_start     one-cycle pulse at start of vertical blank
//  pix_active      timing stage is in the visible region
//  pix_x, pix_y    current screen coordinate
//  r_out..b_out    pixel colour, valid 2 cycles after pix_* were presented
module vga_frame_buffer
  import vga_frame_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  vga_frame_buffer_if.slave    bus,
  input  logic                 frame_start,
  input  logic                 pix_active,
  input  logic [9:0]           pix_x,
  input  logic [8:0]           pix_y,
  output logic                 r_out,
  output logic                 g_out,
  output logic                 b_out
);

  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              front_q, front_d;
  logic              pending_q, pending_d;
  logic              wr_ready_q;
  logic              swap_fire;

  // Control FSM and swap bookkeeping
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.clear_req) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end
      end
      StClear: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_CELL) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A request arriving with frame_start counts immediately; a swap is never taken mid-clear.
    swap_fire = frame_start && (state_q == StIdle) && (pending_q || bus.swap_req);
    front_d   = front_q ^ swap_fire;
    pending_d = swap_fire ? 1'b0 : (pending_q | bus.swap_req);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      clr_cnt_q  <= '0;
      front_q    <= 1'b0;
      pending_q  <= 1'b0;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      front_q    <= front_d;
      pending_q  <= pending_d;
      // Registered so ready stays low through reset and rises one cycle after release.
      wr_ready_q <= (state_d == StIdle);
    end
  end

  assign bus.wr_ready   = wr_ready_q;
  assign bus.clear_busy = (state_q == StClear);
  assign bus.swap_done  = swap_fire;

  // Write port: clear sweep or accepted cell write, always into the current back bank.
  // Using front_q (pre-toggle) sends a write in the swap cycle to the old back bank.
  logic                clearing;
  logic                wr_accept;
  logic                wr_in_range;
  logic                ram_we;
  logic [ADDR_W:0]     ram_waddr;
  logic [RGB_W-1:0]    ram_wdata;

  always_comb begin
    clearing    = (state_q == StClear);
    wr_accept   = bus.wr_valid && wr_ready_q;
    wr_in_range = (bus.wr_x <= LAST_X) && (bus.wr_y <= LAST_Y);
    ram_we      = clearing || (wr_accept && wr_in_range);
    ram_waddr   = {~front_q, clearing ? clr_cnt_q : cell_addr(bus.wr_y, bus.wr_x)};
    ram_wdata   = clearing ? '0 : bus.wr_rgb;
  end

  // Read pipeline: stage 1 samples coordinate and bank, RAM registers data, stage 2 gates it.
  logic [7:0]       cx_q;
  logic [6:0]       cy_q;
  logic             bank_q;
  logic             act1_q, act2_q;
  logic [ADDR_W:0]  ram_raddr;
  logic [RGB_W-1:0] ram_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cx_q   <= '0;
      cy_q   <= '0;
      bank_q <= 1'b0;
      act1_q <= 1'b0;
      act2_q <= 1'b0;
    end else begin
      cx_q   <= pix_x[9:CELL_SHIFT];
      cy_q   <= pix_y[8:CELL_SHIFT];
      // Bank captured with the coordinate so in-flight pixels finish from the old bank.
      bank_q <= front_q;
      act1_q <= pix_active;
      act2_q <= act1_q;
    end
  end

  assign ram_raddr = {bank_q, cell_addr(cy_q, cx_q)};

  vga_frame_buffer_ram #(
    .AddrW(ADDR_W + 1),
    .DataW(RGB_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  assign {r_out, g_out, b_out} = act2_q ? ram_rdata : '0;

endmodule

// File: tb/tb_vga_frame_buffer.sv
module tb_vga_frame_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       pix_active;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic       r_out, g_out, b_out;

  always #5 clk = ~clk;

  vga_frame_buffer_if bus_if ();

  vga_frame_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus_if),
    .frame_start(frame_start),
    .pix_active (pix_active),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .r_out      (r_out),
    .g_out      (g_out),
    .b_out      (b_out)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected colour pushed when a pixel is driven, popped 2 cycles later.
  logic [2:0] sb_q[$];
  string      sb_tag[$];
  logic       vld_drv = 1'b0;
  logic       mark1 = 1'b0;
  logic       mark2 = 1'b0;
  logic [2:0] exp_v;
  string      tag_v;

  always @(posedge clk) begin
    mark1 <= vld_drv;
    mark2 <= mark1;
  end

  always @(negedge clk) begin
    if (mark2) begin
      check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        exp_v = sb_q.pop_front();
        tag_v = sb_tag.pop_front();
        check(tag_v, 32'({r_out, g_out, b_out}), 32'(exp_v));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_px(input int x, input int y, input logic act, input logic [2:0] exp,
                          input string tag);
    pix_x      = 10'(x);
    pix_y      = 9'(y);
    pix_active = act;
    vld_drv    = 1'b1;
    sb_q.push_back(exp);
    sb_tag.push_back($sformatf("%s(%0d,%0d)", tag, x, y));
    cyc();
  endtask

  task automatic end_px();
    vld_drv    = 1'b0;
    pix_active = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic write_cell(input int x, input int y, input logic [2:0] rgb, input string tag);
    bus_if.wr_valid = 1'b1;
    bus_if.wr_x     = 8'(x);
    bus_if.wr_y     = 7'(y);
    bus_if.wr_rgb   = rgb;
    @(negedge clk);
    check(tag, 32'(bus_if.wr_ready), 32'd1);
    cyc();
    bus_if.wr_valid = 1'b0;
  endtask

  task automatic do_swap(input string tag);
    bus_if.swap_req = 1'b1;
    cyc();
    bus_if.swap_req = 1'b0;
    frame_start     = 1'b1;
    @(negedge clk);
    check(tag, 32'(bus_if.swap_done), 32'd1);
    cyc();
    frame_start = 1'b0;
  endtask

  // Runs one clear; optionally requests a swap and pulses frame_start part-way through.
  task automatic run_clear(input bit inject, output int n, output int bad, output int done);
    bus_if.clear_req = 1'b1;
    cyc();
    bus_if.clear_req = 1'b0;
    n    = 0;
    bad  = 0;
    done = 0;
    while (n < 20000) begin
      @(negedge clk);
      if (!bus_if.clear_busy) break;
      n++;
      if (bus_if.wr_ready !== 1'b0) bad++;
      if (inject && n == 100) bus_if.swap_req = 1'b1;
      if (inject && n == 200) begin
        frame_start = 1'b1;
        #1;
        if (bus_if.swap_done !== 1'b0) done++;
      end
      cyc();
      bus_if.swap_req = 1'b0;
      frame_start     = 1'b0;
    end
    cyc();
  endtask

  int n_clr, n_bad, n_done;

  initial begin
    reset            = 1'b1;
    frame_start      = 1'b0;
    pix_active       = 1'b0;
    pix_x            = '0;
    pix_y            = '0;
    bus_if.wr_valid  = 1'b0;
    bus_if.wr_x      = '0;
    bus_if.wr_y      = '0;
    bus_if.wr_rgb    = '0;
    bus_if.clear_req = 1'b0;
    bus_if.swap_req  = 1'b0;

    // Reset state
    repeat (3) cyc();
    @(negedge clk);
    check("rst_wr_ready", 32'(bus_if.wr_ready), 32'd0);
    check("rst_clear_busy", 32'(bus_if.clear_busy), 32'd0);
    check("rst_swap_done", 32'(bus_if.swap_done), 32'd0);
    check("rst_rgb", 32'({r_out, g_out, b_out}), 32'd0);
    cyc();
    reset = 1'b0;
    check("rdy_at_release", 32'(bus_if.wr_ready), 32'd0);
    cyc();
    check("rdy_after_release", 32'(bus_if.wr_ready), 32'd1);

    // Reset in the middle of a clear aborts it
    bus_if.clear_req = 1'b1;
    cyc();
    bus_if.clear_req = 1'b0;
    repeat (50) cyc();
    check("midclear_busy", 32'(bus_if.clear_busy), 32'd1);
    check("midclear_rdy", 32'(bus_if.wr_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(bus_if.clear_busy), 32'd0);
    check("abort_rdy", 32'(bus_if.wr_ready), 32'd0);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    check("abort_rdy_release", 32'(bus_if.wr_ready), 32'd1);
    check("abort_busy_release", 32'(bus_if.clear_busy), 32'd0);

    // Full clear of bank 1 with a deferred swap
    run_clear(1'b1, n_clr, n_bad, n_done);
    check("clear_len", 32'(n_clr), 32'd19200);
    check("clear_rdy_low", 32'(n_bad), 32'd0);
    check("clear_no_swap", 32'(n_done), 32'd0);
    frame_start = 1'b1;
    @(negedge clk);
    check("deferred_swap", 32'(bus_if.swap_done), 32'd1);
    cyc();
    frame_start = 1'b0;
    @(negedge clk);
    check("swap_one_shot", 32'(bus_if.swap_done), 32'd0);
    cyc();

    // Front is now bank 1; clear bank 0 too
    run_clear(1'b0, n_clr, n_bad, n_done);
    check("clear2_len", 32'(n_clr), 32'd19200);

    // Single cell write, swap, read back the 4x4 block and its neighbours
    write_cell(5, 3, 3'b101, "wr_5_3");
    do_swap("swap_a");
    for (int y = 11; y <= 16; y++) begin
      for (int x = 19; x <= 24; x++) begin
        drive_px(x, y, 1'b1,
                 (x >= 20 && x <= 23 && y >= 12 && y <= 15) ? 3'b101 : 3'b000, "blk");
      end
    end
    end_px();

    // Out-of-range write is accepted but dropped
    write_cell(160, 0, 3'b111, "wr_oob");
    do_swap("swap_b");
    drive_px(0, 4, 1'b1, 3'b000, "oob_cell01");
    drive_px(636, 0, 1'b1, 3'b000, "oob_cell159");
    drive_px(0, 0, 1'b1, 3'b000, "oob_cell00");
    end_px();

    // Swap request, frame_start and a write all in one cycle
    bus_if.swap_req = 1'b1;
    frame_start     = 1'b1;
    bus_if.wr_valid = 1'b1;
    bus_if.wr_x     = 8'd0;
    bus_if.wr_y     = 7'd0;
    bus_if.wr_rgb   = 3'b010;
    @(negedge clk);
    check("same_cycle_swap", 32'(bus_if.swap_done), 32'd1);
    check("same_cycle_rdy", 32'(bus_if.wr_ready), 32'd1);
    cyc();
    bus_if.swap_req = 1'b0;
    frame_start     = 1'b0;
    bus_if.wr_valid = 1'b0;
    drive_px(0, 0, 1'b1, 3'b010, "sc_00");
    drive_px(3, 3, 1'b1, 3'b010, "sc_33");
    drive_px(4, 0, 1'b1, 3'b000, "sc_40");
    drive_px(21, 13, 1'b1, 3'b101, "sc_old");
    end_px();

    // Inactive region blanks a lit cell
    drive_px(21, 13, 1'b0, 3'b000, "inactive");
    drive_px(21, 13, 1'b1, 3'b101, "active_again");
    drive_px(22, 14, 1'b0, 3'b000, "inactive2");
    end_px();

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
